// File: rtl/sram_arbiter_2p_if.sv
// ---------------------------------------------------------------------------
// sram_arbiter_2p_if
//
// Purpose: bundles every handshake and data signal of the two-port SRAM
// arbiter so the arbiter and its environment connect through one port.
//
// Parameters:
//   AW  SRAM word address width
//   DW  SRAM data width
//
// Signal summary (direction as seen by the arbiter):
//   p0_req/p1_req    in   port request, held with wr/addr/din until ack
//   p0_wr/p1_wr      in   1 = write, 0 = read
//   p0_addr/p1_addr  in   word address
//   p0_din/p1_din    in   write data
//   p0_ack/p1_ack    out  one-cycle completion pulse
//   p0_dout/p1_dout  out  read data, held until that port's next read
//   mem_req          out  one-cycle start pulse to the SRAM controller
//   mem_wr           out  direction to controller
//   mem_addr         out  registered address to controller
//   mem_din          out  registered write data to controller
//   mem_ready        in   controller completion pulse
//   mem_dout         in   controller read data, valid with mem_ready
//   busy             out  high whenever a transaction is in progress
//
// Modports:
//   master  the arbiter itself (drives acks, read data and the memory side)
//   slave   the environment: requesting clients plus the SRAM controller
//
// Handshake: a client raises pn_req with wr/addr/din stable and keeps it all
// high until it sees pn_ack for one cycle; the arbiter emits mem_req for one
// cycle and the controller answers with a single-cycle mem_ready, with
// mem_dout valid in that same cycle.
// ---------------------------------------------------------------------------
interface sram_arbiter_2p_if #(
    parameter int AW = 17,
    parameter int DW = 16
);
    logic          p0_req;
    logic          p0_wr;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_din;
    logic          p0_ack;
    logic [DW-1:0] p0_dout;

    logic          p1_req;
    logic          p1_wr;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_din;
    logic          p1_ack;
    logic [DW-1:0] p1_dout;

    logic          mem_req;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_ready;
    logic [DW-1:0] mem_dout;

    logic          busy;

    modport master (
        input  p0_req, p0_wr, p0_addr, p0_din,
        input  p1_req, p1_wr, p1_addr, p1_din,
        input  mem_ready, mem_dout,
        output p0_ack, p0_dout, p1_ack, p1_dout,
        output mem_req, mem_wr, mem_addr, mem_din,
        output busy
    );

    modport slave (
        output p0_req, p0_wr, p0_addr, p0_din,
        output p1_req, p1_wr, p1_addr, p1_din,
        output mem_ready, mem_dout,
        input  p0_ack, p0_dout, p1_ack, p1_dout,
        input  mem_req, mem_wr, mem_addr, mem_din,
        input  busy
    );
endinterface

// File: rtl/sram_arbiter_2p.sv
// ---------------------------------------------------------------------------
// sram_arbiter_2p
//
// Purpose: shares one SRAM controller between two client ports. Exactly one
// transaction is in flight at a time; the FSM walks IDLE -> ISSUE -> WAIT ->
// ACK -> IDLE for every transaction.
//
// Configuration macro:
//   SRAM_ARB_ROUND_ROBIN_EN  defined: simultaneous requests go to the port
//                            not granted last (last-grant register resets
//                            to port 1, so port 0 wins the first tie).
//                            undefined (default): port 0 always wins a tie
//                            and no last-grant register exists.
//
// Ports:
//   clk      single clock, rising edge
//   rst      synchronous, active-high reset; aborts any transaction
//   arb_if   sram_arbiter_2p_if.master (client ports + controller side)
//   state_o  current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 ACK) for debug
//
// Handshake: clients hold pn_req with stable wr/addr/din until pn_ack; the
// request is sampled only in IDLE. mem_req is high for the ISSUE cycle only,
// mem_ready is honoured only in WAIT, and pn_ack is high for the ACK cycle
// only. mem_wr/mem_addr/mem_din are loaded in IDLE and stay put until the
// next grant, so they are stable from ISSUE through ACK.
// ---------------------------------------------------------------------------
module sram_arbiter_2p #(
    parameter int AW = 17,
    parameter int DW = 16
) (
    input  logic                clk,
    input  logic                rst,
    sram_arbiter_2p_if.master   arb_if,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t        state_q;
    logic          gnt_q;        // port owning the transaction in flight
    logic          mem_req_q;
    logic          mem_wr_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_din_q;
    logic          p0_ack_q;
    logic          p1_ack_q;
    logic [DW-1:0] p0_dout_q;
    logic [DW-1:0] p1_dout_q;
    logic          busy_q;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic          last_q;       // port granted most recently
`endif

    // Port chosen if a grant is made in this IDLE cycle.
    logic          any_req;
    logic          gnt_d;

    always_comb begin
        any_req = arb_if.p0_req | arb_if.p1_req;
        gnt_d   = 1'b0;
        if (arb_if.p0_req && arb_if.p1_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            gnt_d = ~last_q;
`else
            gnt_d = 1'b0;
`endif
        end else if (arb_if.p1_req) begin
            gnt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            p0_ack_q   <= 1'b0;
            p1_ack_q   <= 1'b0;
            p0_dout_q  <= '0;
            p1_dout_q  <= '0;
            busy_q     <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_q     <= 1'b1;
`endif
        end else begin
            // Pulse outputs fall back to zero unless the next state needs them.
            mem_req_q <= 1'b0;
            p0_ack_q  <= 1'b0;
            p1_ack_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt_q      <= gnt_d;
                        mem_wr_q   <= gnt_d ? arb_if.p1_wr   : arb_if.p0_wr;
                        mem_addr_q <= gnt_d ? arb_if.p1_addr : arb_if.p0_addr;
                        mem_din_q  <= gnt_d ? arb_if.p1_din  : arb_if.p0_din;
                        mem_req_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_ISSUE;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                        last_q     <= gnt_d;
`endif
                    end
                end

                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end

                ST_WAIT: begin
                    // No timeout: the controller is trusted to answer.
                    if (arb_if.mem_ready) begin
                        if (!mem_wr_q) begin
                            if (gnt_q) begin
                                p1_dout_q <= arb_if.mem_dout;
                            end else begin
                                p0_dout_q <= arb_if.mem_dout;
                            end
                        end
                        if (gnt_q) begin
                            p1_ack_q <= 1'b1;
                        end else begin
                            p0_ack_q <= 1'b1;
                        end
                        state_q <= ST_ACK;
                    end
                end

                ST_ACK: begin
                    // Requests still held now are new transactions, sampled
                    // in the IDLE cycle that follows.
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign arb_if.mem_req  = mem_req_q;
    assign arb_if.mem_wr   = mem_wr_q;
    assign arb_if.mem_addr = mem_addr_q;
    assign arb_if.mem_din  = mem_din_q;
    assign arb_if.p0_ack   = p0_ack_q;
    assign arb_if.p1_ack   = p1_ack_q;
    assign arb_if.p0_dout  = p0_dout_q;
    assign arb_if.p1_dout  = p1_dout_q;
    assign arb_if.busy     = busy_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_sram_arbiter_2p.sv
module tb_sram_arbiter_2p;
  localparam int AW = 17;
  localparam int DW = 16;

  typedef struct {
    bit            port;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    int            lat;
    logic [DW-1:0] rdata_exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state;

  always #5 clk = ~clk;

  sram_arbiter_2p_if #(.AW(AW), .DW(DW)) bus_if ();

  sram_arbiter_2p #(.AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .arb_if  (bus_if.master),
    .state_o (state)
  );

  int checks = 0;
  int passed = 0;
  logic [DW-1:0] model [int];
  logic [DW-1:0] exp_dout [2];
  vec_t vecs [6];
  int   exp_g [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_douts(input string tag);
    check({tag, "_p0_dout"}, 32'(bus_if.p0_dout), 32'(exp_dout[0]));
    check({tag, "_p1_dout"}, 32'(bus_if.p1_dout), 32'(exp_dout[1]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_port(input bit port, input logic req, input logic wr,
                          input logic [AW-1:0] addr, input logic [DW-1:0] din);
    if (!port) begin
      bus_if.p0_req = req; bus_if.p0_wr = wr; bus_if.p0_addr = addr; bus_if.p0_din = din;
    end else begin
      bus_if.p1_req = req; bus_if.p1_wr = wr; bus_if.p1_addr = addr; bus_if.p1_din = din;
    end
  endtask

  // Returns the number of cycles until mem_req is seen (bounded at 10).
  task automatic wait_mem_req(output int cyc);
    @(negedge clk);
    cyc = 1;
    while (!bus_if.mem_req && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Controller model. Entered at the ISSUE negedge, leaves at the ACK negedge.
  task automatic serve(input int lat, output int who);
    logic [AW-1:0] a;
    logic          w;
    logic [DW-1:0] d;
    a = bus_if.mem_addr;
    w = bus_if.mem_wr;
    d = bus_if.mem_din;
    @(negedge clk);
    check("mem_req_one_cycle", 32'(bus_if.mem_req), 32'd0);
    for (int i = 0; i < lat; i++) begin
      check("no_early_ack", {30'd0, bus_if.p0_ack, bus_if.p1_ack}, 32'd0);
      @(negedge clk);
    end
    check("addr_stable_wait", 32'(bus_if.mem_addr), 32'(a));
    bus_if.mem_ready = 1'b1;
    if (w) begin
      bus_if.mem_dout = 16'hDEAD;
      model[int'(a)] = d;
    end else begin
      bus_if.mem_dout = model.exists(int'(a)) ? model[int'(a)] : '0;
    end
    @(negedge clk);
    bus_if.mem_ready = 1'b0;
    bus_if.mem_dout  = '0;
    check("addr_stable_ack", 32'(bus_if.mem_addr), 32'(a));
    check("wr_stable_ack", 32'(bus_if.mem_wr), 32'(w));
    check("din_stable_ack", 32'(bus_if.mem_din), 32'(d));
    check("single_ack", 32'(bus_if.p0_ack & bus_if.p1_ack), 32'd0);
    who = bus_if.p0_ack ? 0 : (bus_if.p1_ack ? 1 : -1);
  endtask

  task automatic run_txn(input vec_t v);
    int cyc;
    int who;
    @(negedge clk);
    set_port(v.port, 1'b1, v.wr, v.addr, v.din);
    wait_mem_req(cyc);
    check("req_to_mem_req_latency", 32'(cyc), 32'd1);
    if (!bus_if.mem_req) begin
      set_port(v.port, 1'b0, 1'b0, '0, '0);
      return;
    end
    check("mem_wr", 32'(bus_if.mem_wr), 32'(v.wr));
    check("mem_addr", 32'(bus_if.mem_addr), 32'(v.addr));
    check("mem_din", 32'(bus_if.mem_din), 32'(v.din));
    check("busy_issue", 32'(bus_if.busy), 32'd1);
    serve(v.lat, who);
    check("ack_port", 32'(who), 32'(v.port));
    set_port(v.port, 1'b0, 1'b0, '0, '0);
    if (!v.wr) exp_dout[v.port] = v.rdata_exp;
    check_douts("txn");
    @(negedge clk);
    check("idle_after_ack_busy", 32'(bus_if.busy), 32'd0);
    check("idle_after_ack_acks", {30'd0, bus_if.p0_ack, bus_if.p1_ack}, 32'd0);
    check("idle_after_ack_state", 32'(state), 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    int cyc;
    int who;
    vec_t rd;

    vecs[0] = '{port: 1'b0, wr: 1'b1, addr: 17'h00010, din: 16'hA5A5, lat: 0, rdata_exp: 16'h0000};
    vecs[1] = '{port: 1'b0, wr: 1'b0, addr: 17'h00010, din: 16'h0000, lat: 2, rdata_exp: 16'hA5A5};
    vecs[2] = '{port: 1'b1, wr: 1'b1, addr: 17'h1FFFF, din: 16'hFFFF, lat: 1, rdata_exp: 16'h0000};
    vecs[3] = '{port: 1'b1, wr: 1'b0, addr: 17'h1FFFF, din: 16'h0000, lat: 0, rdata_exp: 16'hFFFF};
    vecs[4] = '{port: 1'b0, wr: 1'b1, addr: 17'h00003, din: 16'h1234, lat: 3, rdata_exp: 16'h0000};
    vecs[5] = '{port: 1'b1, wr: 1'b0, addr: 17'h00003, din: 16'h0000, lat: 1, rdata_exp: 16'h1234};
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    exp_dout[0] = '0;
    exp_dout[1] = '0;

    rst = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    bus_if.mem_ready = 1'b0;
    bus_if.mem_dout  = '0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_mem_req", 32'(bus_if.mem_req), 32'd0);
    check("rst_mem_wr", 32'(bus_if.mem_wr), 32'd0);
    check("rst_mem_addr", 32'(bus_if.mem_addr), 32'd0);
    check("rst_mem_din", 32'(bus_if.mem_din), 32'd0);
    check("rst_acks", {30'd0, bus_if.p0_ack, bus_if.p1_ack}, 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check_douts("rst");
    rst = 1'b0;

    // Single-port transactions, including max address and dout isolation
    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Simultaneous, continuously held requests
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b1, 17'h00001, 16'h1111);
    set_port(1'b1, 1'b1, 1'b1, 17'h00002, 16'h2222);
    for (int i = 0; i < 4; i++) begin
      wait_mem_req(cyc);
      check("both_req_latency", 32'(cyc), (i == 0) ? 32'd1 : 32'd2);
      check("both_req_addr", 32'(bus_if.mem_addr), (exp_g[i] == 1) ? 32'h2 : 32'h1);
      serve(0, who);
      check("both_req_grant", 32'(who), 32'(exp_g[i]));
    end
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
`else
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    wait_mem_req(cyc);
    check("p1_after_p0_drop_addr", 32'(bus_if.mem_addr), 32'h2);
    serve(0, who);
    check("p1_after_p0_drop_grant", 32'(who), 32'd1);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
`endif
    @(negedge clk);
    check("both_req_idle", 32'(bus_if.busy), 32'd0);
    check_douts("both_req");

    // Reset during WAIT of a p0 read
    set_port(1'b0, 1'b1, 1'b0, 17'h00010, 16'h0000);
    wait_mem_req(cyc);
    check("abort_mem_req", 32'(bus_if.mem_req), 32'd1);
    @(negedge clk);
    check("abort_in_wait", 32'(state), 32'd2);
    rst = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    exp_dout[0] = '0;
    exp_dout[1] = '0;
    check("abort_busy", 32'(bus_if.busy), 32'd0);
    check("abort_mem_req_low", 32'(bus_if.mem_req), 32'd0);
    check("abort_mem_addr", 32'(bus_if.mem_addr), 32'd0);
    check_douts("abort");
    for (int i = 0; i < 3; i++) begin
      check("abort_no_ack", {30'd0, bus_if.p0_ack, bus_if.p1_ack}, 32'd0);
      check("abort_idle", 32'(state), 32'd0);
      @(negedge clk);
    end
    rd = '{port: 1'b0, wr: 1'b0, addr: 17'h00010, din: 16'h0000, lat: 1, rdata_exp: 16'hA5A5};
    run_txn(rd);

    // Spurious mem_ready in IDLE
    bus_if.mem_ready = 1'b1;
    bus_if.mem_dout  = 16'hBEEF;
    @(negedge clk);
    bus_if.mem_ready = 1'b0;
    bus_if.mem_dout  = '0;
    for (int i = 0; i < 2; i++) begin
      check("spurious_no_ack", {30'd0, bus_if.p0_ack, bus_if.p1_ack}, 32'd0);
      check("spurious_idle", 32'(state), 32'd0);
      check("spurious_busy", 32'(bus_if.busy), 32'd0);
      @(negedge clk);
    end
    check_douts("spurious");

    // p1 request arriving while p0 is in WAIT
    set_port(1'b0, 1'b1, 1'b0, 17'h00001, 16'h0000);
    wait_mem_req(cyc);
    check("late_p1_p0_addr", 32'(bus_if.mem_addr), 32'h1);
    @(negedge clk);
    set_port(1'b1, 1'b1, 1'b0, 17'h00002, 16'h0000);
    @(negedge clk);
    check("late_p1_ignored_addr", 32'(bus_if.mem_addr), 32'h1);
    check("late_p1_no_mem_req", 32'(bus_if.mem_req), 32'd0);
    check("late_p1_still_wait", 32'(state), 32'd2);
    bus_if.mem_ready = 1'b1;
    bus_if.mem_dout  = model[1];
    @(negedge clk);
    bus_if.mem_ready = 1'b0;
    bus_if.mem_dout  = '0;
    check("late_p1_p0_ack", 32'(bus_if.p0_ack), 32'd1);
    check("late_p1_no_p1_ack", 32'(bus_if.p1_ack), 32'd0);
    exp_dout[0] = 16'h1111;
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    wait_mem_req(cyc);
    check("late_p1_latency", 32'(cyc), 32'd2);
    check("late_p1_addr", 32'(bus_if.mem_addr), 32'h2);
    serve(1, who);
    check("late_p1_grant", 32'(who), 32'd1);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    exp_dout[1] = 16'h2222;
    check_douts("late_p1");
    @(negedge clk);
    check("final_idle", 32'(state), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
